// File: rtl/summer_pkg.sv
// Shared types and helpers for the AXI-Stream packet summer.
package summer_pkg;

   localparam int BUS_WIDTH    = 32;
   localparam int STRB_W       = BUS_WIDTH / 8;
   localparam int LEN_FLAG_BIT = 31;

   typedef logic [1:0] state_t;
   localparam state_t ACCUM    = 2'd0;
   localparam state_t SEND_CNT = 2'd1;
   localparam state_t SEND_SUM = 2'd2;

   // Bytes whose strobe bit is clear contribute zero to the sum.
   function automatic logic [BUS_WIDTH-1:0] strb_mask(
      input logic [BUS_WIDTH-1:0] data,
      input logic [STRB_W-1:0]    strb
   );
      logic [BUS_WIDTH-1:0] masked;
      masked = '0;
      for (int b = 0; b < STRB_W; b++) begin
         masked[8*b +: 8] = strb[b] ? data[8*b +: 8] : 8'h00;
      end
      return masked;
   endfunction

endpackage

// File: rtl/axis_packet_summer.sv
// Sums each tlast-delimited input packet and emits a count beat then a sum beat.
// Optional macro SUMMER_LEN_CHECK_EN flags packets longer than MAX_WORDS in count bit 31.
module axis_packet_summer
   import summer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16,
   parameter int MAX_WORDS  = 4096
) (
   input  logic                    axis_aclk,
   input  logic                    axis_reset,
   input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
   input  logic                    s01_axis_tvalid,
   input  logic                    s01_axis_tlast,
   output logic                    s01_axis_tready,
   output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
   output logic                    m01_axis_tvalid,
   output logic                    m01_axis_tlast,
   input  logic                    m01_axis_tready
);

   if (DATA_WIDTH != BUS_WIDTH || CNT_WIDTH > LEN_FLAG_BIT || CNT_WIDTH < 1 || MAX_WORDS < 1) begin : gBadParams
      $error("axis_packet_summer: unsupported parameter combination");
   end

   state_t                  r_state;
   logic [BUS_WIDTH-1:0]    r_sum;
   logic [CNT_WIDTH-1:0]    r_cnt;
   logic [BUS_WIDTH-1:0]    r_outSum;
   logic                    r_sReady;
   logic [BUS_WIDTH-1:0]    r_mData;
   logic [STRB_W-1:0]       r_mStrb;
   logic                    r_mValid;
   logic                    r_mLast;

   logic                    w_accept;
   logic [BUS_WIDTH-1:0]    w_sumNext;
   logic [CNT_WIDTH-1:0]    w_cntNext;
   logic                    w_lenFlag;
   logic [BUS_WIDTH-1:0]    w_cntWord;

   assign w_accept  = s01_axis_tvalid & r_sReady;
   assign w_sumNext = r_sum + strb_mask(s01_axis_tdata, s01_axis_tstrb);
   assign w_cntNext = (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1);

`ifdef SUMMER_LEN_CHECK_EN
   assign w_lenFlag = (32'(w_cntNext) > 32'(MAX_WORDS));
`else
   assign w_lenFlag = 1'b0;
`endif

   assign w_cntWord = {w_lenFlag, LEN_FLAG_BIT'(w_cntNext)};

   // Output registers are loaded on the transition into each send state so
   // they stay frozen while the downstream holds tready low.
   always_ff @(posedge axis_aclk) begin
      if (axis_reset) begin
         r_state  <= ACCUM;
         r_sum    <= '0;
         r_cnt    <= '0;
         r_outSum <= '0;
         r_sReady <= 1'b0;
         r_mData  <= '0;
         r_mStrb  <= '0;
         r_mValid <= 1'b0;
         r_mLast  <= 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               r_sReady <= 1'b1;
               if (w_accept) begin
                  if (s01_axis_tlast) begin
                     r_outSum <= w_sumNext;
                     r_sum    <= '0;
                     r_cnt    <= '0;
                     r_mData  <= w_cntWord;
                     r_mStrb  <= '1;
                     r_mValid <= 1'b1;
                     r_mLast  <= 1'b0;
                     r_sReady <= 1'b0;
                     r_state  <= SEND_CNT;
                  end else begin
                     r_sum <= w_sumNext;
                     r_cnt <= w_cntNext;
                  end
               end
            end
            SEND_CNT: begin
               if (m01_axis_tready) begin
                  r_mData <= r_outSum;
                  r_mLast <= 1'b1;
                  r_state <= SEND_SUM;
               end
            end
            SEND_SUM: begin
               if (m01_axis_tready) begin
                  r_mData  <= '0;
                  r_mStrb  <= '0;
                  r_mValid <= 1'b0;
                  r_mLast  <= 1'b0;
                  r_sReady <= 1'b1;
                  r_state  <= ACCUM;
               end
            end
            default: begin
               r_state <= ACCUM;
            end
         endcase
      end
   end

   assign s01_axis_tready = r_sReady;
   assign m01_axis_tdata  = r_mData;
   assign m01_axis_tstrb  = r_mStrb;
   assign m01_axis_tvalid = r_mValid;
   assign m01_axis_tlast  = r_mLast;

endmodule
